// File: rtl/i2c_master_wr.sv
// i2c_master_wr
// Single-byte I2C write initiator. A start request sends START, the 7-bit
// address with R/W=0, checks ACK, sends one data byte, checks ACK and ends
// with STOP. SCL and SDA are open-drain (drive 0 or release to z).
//
// Handshake: a request is taken when start=1 is sampled while busy=0. busy
// then stays high until the STOP is complete. A start seen while busy=1 is
// dropped, not queued. done pulses for one cycle when the transfer ends.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   start        request pulse
//   addr[6:0]    target address, captured on accept
//   wdata[7:0]   data byte, captured on accept
//   busy         transfer in progress
//   done         one-cycle end-of-transfer pulse
//   ack_err      sticky NACK flag, cleared on the next accept
//   o_dbg_state  current FSM state (state_t encoding)
//   scl, sda     open-drain bus lines
//
// Parameter CLK_DIV: clk cycles per SCL quarter period (2..65535).
// Optional macro I2C_MASTER_STRETCH_EN: the quarter counter holds in q2 while
// the released scl line still reads 0 (clock stretching, no timeout).
module i2c_master_wr #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [2:0] o_dbg_state,
  inout  wire        scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_ACK1  = 3'd3,
    S_DATA  = 3'd4,
    S_ACK2  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(CLK_DIV - 1);

  state_t      r_state, w_state_n;
  logic [1:0]  r_q, w_q_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [7:0]  r_data, w_data_n;
  logic        r_ack_ok, w_ack_ok_n;
  logic        r_busy, w_busy_n;
  logic        r_done, w_done_n;
  logic        r_ack_err, w_ack_err_n;
  logic        r_scl_low, w_scl_low_n;
  logic        r_sda_low, w_sda_low_n;
  logic        w_hold;

`ifdef I2C_MASTER_STRETCH_EN
  // scl is always released in q2, so a low read means a target is stretching.
  assign w_hold = (r_state != S_IDLE) && (r_q == 2'd2) && (scl == 1'b0);
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_state_n   = r_state;
    w_q_n       = r_q;
    w_cnt_n     = r_cnt;
    w_bit_n     = r_bit;
    w_shift_n   = r_shift;
    w_data_n    = r_data;
    w_ack_ok_n  = r_ack_ok;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_ack_err_n = r_ack_err;

    if (r_state == S_IDLE) begin
      if (start) begin
        w_state_n   = S_START;
        w_q_n       = 2'd0;
        w_cnt_n     = 16'd0;
        w_bit_n     = 3'd0;
        w_shift_n   = {addr, 1'b0};
        w_data_n    = wdata;
        w_busy_n    = 1'b1;
        w_ack_err_n = 1'b0;
        w_ack_ok_n  = 1'b0;
      end
    end else if (!w_hold) begin
      if (r_cnt != LP_LAST) begin
        w_cnt_n = r_cnt + 16'd1;
      end else begin
        w_cnt_n = 16'd0;
        w_q_n   = r_q + 2'd1;
        // Last clk of q2 in an ACK slot: SCL has been high for a full quarter.
        if (r_q == 2'd2 && (r_state == S_ACK1 || r_state == S_ACK2)) begin
          w_ack_ok_n = (sda == 1'b0);
        end
        if (r_q == 2'd3) begin
          case (r_state)
            S_START: w_state_n = S_ADDR;
            S_ADDR, S_DATA: begin
              if (r_bit == 3'd7) begin
                w_bit_n   = 3'd0;
                w_state_n = (r_state == S_ADDR) ? S_ACK1 : S_ACK2;
              end else begin
                w_bit_n   = r_bit + 3'd1;
                w_shift_n = {r_shift[6:0], 1'b0};
              end
            end
            S_ACK1: begin
              if (r_ack_ok) begin
                w_state_n = S_DATA;
                w_shift_n = r_data;
              end else begin
                w_ack_err_n = 1'b1;
                w_state_n   = S_STOP;
              end
            end
            S_ACK2: begin
              if (!r_ack_ok) w_ack_err_n = 1'b1;
              w_state_n = S_STOP;
            end
            S_STOP: begin
              w_state_n = S_IDLE;
              w_busy_n  = 1'b0;
              w_done_n  = 1'b1;
            end
            default: w_state_n = S_IDLE;
          endcase
        end
      end
    end

    // Line drives are decoded from the next state so the output registers
    // change on the same edge that enters a quarter (glitch-free pins).
    w_scl_low_n = 1'b0;
    w_sda_low_n = 1'b0;
    case (w_state_n)
      S_START: w_sda_low_n = w_q_n[1];
      S_ADDR, S_DATA: begin
        w_scl_low_n = !w_q_n[1];
        w_sda_low_n = !w_shift_n[7];
      end
      S_ACK1, S_ACK2: w_scl_low_n = !w_q_n[1];
      S_STOP: begin
        w_scl_low_n = (w_q_n == 2'd0);
        w_sda_low_n = !w_q_n[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_q       <= 2'd0;
      r_cnt     <= 16'd0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_data    <= 8'd0;
      r_ack_ok  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_q       <= w_q_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_shift   <= w_shift_n;
      r_data    <= w_data_n;
      r_ack_ok  <= w_ack_ok_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_ack_err <= w_ack_err_n;
      r_scl_low <= w_scl_low_n;
      r_sda_low <= w_sda_low_n;
    end
  end

  assign scl         = r_scl_low ? 1'b0 : 1'bz;
  assign sda         = r_sda_low ? 1'b0 : 1'bz;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign o_dbg_state = r_state;

endmodule

// File: doc/i2c_master_wr.md
# i2c_master_wr

Single-byte I2C write initiator: on a `start` request it generates START, sends a 7-bit address with R/W=0, checks the ACK, sends one data byte, checks the ACK, and generates STOP. It drives SCL and SDA open-drain from a single system clock and is the bus-side counterpart of the team's `posedge scl` sampling I2C slave (default slave address 7'h55). Control logic or a testbench uses it to load `address_out`/`data_out` in that slave.

## Interface
- `CLK_DIV`, default 250: `clk` cycles per SCL quarter-period (100 kHz SCL at 100 MHz); legal range 2..65535.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only when `busy`=0.
- `addr`  in  7  target address; captured on accept.
- `wdata`  in  8  data byte; captured on accept.
- `busy`  out  1  high from the cycle after accept through the final STOP quarter.
- `done`  out  1  one-cycle pulse when the transfer ends.
- `ack_err`  out  1  set on any NACK; cleared on the next accept.
- `scl`  inout  1  open-drain: drives 0 or z.
- `sda`  inout  1  open-drain: drives 0 or z.

## Operation
- Reset: `busy`=0, `done`=0, `ack_err`=0, SCL and SDA released (z), state IDLE, counters 0.
- Quarter counter: counts 0..CLK_DIV-1, then advances quarter index q0..q3. Each bit is four quarters.
  - SCL low in q0–q1, released in q2–q3.
  - SDA updates at entry to q0.
  - SDA is sampled at the last `clk` of q2.
- States:
  - IDLE: `start`=1 captures `addr` and `wdata` and goes to START.
  - START:
    - q0–q1: SCL and SDA released.
    - q2–q3: SDA=0 with SCL released.
    - Then goes to ADDR.
  - ADDR: shifts out {addr, 1'b0} MSB first, 8 bits. Bit value 1 means SDA released; 0 means SDA driven low.
  - ACK1: SDA released.
    - Sampled SDA==0: ACK; go to DATA.
    - Otherwise: set `ack_err` and go to STOP.
  - DATA: shifts out `wdata` MSB first, 8 bits.
  - ACK2: SDA released. A NACK sets `ack_err`. Goes to STOP in either case.
  - STOP:
    - q0: SCL and SDA low.
    - q1: SCL released, SDA low.
    - q2–q3: both released.
    - At the end of q3, pulse `done`, drop `busy`, and go to IDLE.
- A `start` while `busy`=1 is ignored, with no queueing.
- SDA reads of z or 1 count as NACK.

## Timing
- Accept: `busy` rises 1 cycle after `start` is sampled, and START q0 begins that same cycle.
- Full transfer: START (4) + ADDR/ACK1 (36) + DATA/ACK2 (36) + STOP (4) = 80 quarters = 80·CLK_DIV cycles from accept to the `done` cycle.
- Address NACK: 44·CLK_DIV cycles.
- `done` is asserted in the cycle after the final STOP clock. `busy` is 0 in that same cycle. `start` may be accepted in the same cycle as `done`.
- Reset mid-transfer releases both lines on the next `clk` edge. No STOP is generated, and `done` is not pulsed.
- Each SDA change occurs at least CLK_DIV cycles away from any SCL rising edge.

## Configuration
- `I2C_MASTER_STRETCH_EN` defined:
  - On entry to q2 and every cycle of q2, if the `scl` input reads 0 while released, the quarter counter holds.
  - Counting resumes on the first cycle `scl` reads 1.
  - There is no timeout.
  - All latencies in Timing lengthen by the stretch duration.
- Not defined: the `scl` input is never read, and timing is exactly as stated.

## Test plan
- CLK_DIV=4, `addr`=7'h55, `wdata`=8'hA5, team slave on bus with pull-ups:
  - `done` exactly 320 cycles after accept.
  - `ack_err`=0.
  - Slave `address_out`=7'h55, `data_out`=8'hA5.
- `addr`=7'h22, no responder: `ack_err`=1, `done` at 176 cycles, no SDA low during the DATA window.
- Responder ACKs address but NACKs data: `ack_err`=1, `done` still at 320 cycles, valid STOP seen.
- `start` pulsed at cycle 50 of an active transfer: ignored, one START only, first transfer data intact.
- `reset` asserted at quarter 30: next cycle SCL=z, SDA=z, `busy`=0, no `done`; new transfer succeeds.
- With `I2C_MASTER_STRETCH_EN`, responder holds SCL low 20 cycles during ACK1: `done` at 340 cycles, data correct.
